mem_sync_arbiter: RTL
=====================

# mem_sync_arbiter

Round-robin arbiter and sequencer that shares the single backing-store row-transfer engine among all per-bank row-cache sync requesters. Each bank's cache-sync logic raises a request when a row must be filled into or written back from its cache. This block grants one bank at a time and issues a latched transfer command over a valid/ready handshake. It waits for the engine's completion, returns a one-cycle done pulse to the granted bank, and drives the aggregate stall seen by the command front end.

## Interface
- BGWIDTH, 2, bank-group index width
- BAWIDTH, 2, bank-in-group index width
- ADDRWIDTH, 17, backing-store row id width
- CHWIDTH, 5, cache row (slot) id width
- TIMEOUT, 1024, max cycles in WAIT before forced completion; 0 disables
- NBANKS (local), 2**(BGWIDTH+BAWIDTH); flat bank index = bg*2**BAWIDTH + b
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sync_req  in  NBANKS  per-bank level request; held until that bank's sync_done
- sync_dir  in  NBANKS  per-bank direction: 0 fill (backing->cache), 1 writeback
- req_row  in  NBANKS x ADDRWIDTH  per-bank row id
- req_crow  in  NBANKS x CHWIDTH  per-bank cache slot
- sync_done  out  NBANKS  one-hot, one-cycle completion pulse
- xfer_valid  out  1  command valid to transfer engine
- xfer_ready  in  1  engine accepts command when valid&ready
- xfer_bank  out  BGWIDTH+BAWIDTH  granted flat bank index
- xfer_row  out  ADDRWIDTH  latched row id
- xfer_crow  out  CHWIDTH  latched cache slot
- xfer_dir  out  1  latched direction
- xfer_ack  in  1  engine completion pulse
- stall  out  1  |sync_req OR state != IDLE
- timeout_err  out  1  sticky, set on WAIT timeout

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any sync_req, pick the first requester scanning from rr_ptr+1 upward, modulo NBANKS. Latch index, row, crow and dir into the xfer_* registers. Go to ISSUE. With no request, stay in IDLE.
- ISSUE: xfer_valid=1. xfer_* stay stable until the edge where xfer_ready=1, then go to WAIT. xfer_ack is ignored in this state.
- WAIT: xfer_valid=0. The wait counter increments each cycle. On xfer_ack go to DONE. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack, set timeout_err and go to DONE.
- DONE: sync_done[granted]=1 for exactly this cycle. rr_ptr <= granted index. Go to IDLE.
- Requesters must deassert sync_req by the edge that ends the DONE cycle. sync_req is sampled only in IDLE.
- Request changes outside IDLE (drop, new req, dir/row change) do not affect the operation in flight. The latched command completes, and done is pulsed regardless.
- xfer_ack outside WAIT is ignored.
- Only one transfer is outstanding at any time.
- Reset (asynchronous, any state, including mid-WAIT):
  - state=IDLE, rr_ptr=NBANKS-1 (bank 0 has first priority), counter=0.
  - All outputs 0: sync_done, xfer_valid, xfer_bank, xfer_row, xfer_crow, xfer_dir, timeout_err.
  - stall follows sync_req combinationally.
  - An abandoned engine command is not re-issued.

## Timing
- Request seen in IDLE at edge t: xfer_valid high in cycle t+1.
- With xfer_ready=1 in the ISSUE cycle and xfer_ack in the first WAIT cycle: sync_done in cycle t+3, IDLE in t+4. That is a 4-cycle minimum turnaround, so back-to-back grants start every 4 cycles.
- Backpressure: each cycle of xfer_ready=0 adds one cycle. xfer_* hold their values and xfer_valid stays high.
- Timeout: WAIT lasts exactly TIMEOUT cycles, then DONE.
- stall is combinational from sync_req and state; all other outputs are registered.
- Counter width: clog2(TIMEOUT+1), minimum 1. It clears on entry to WAIT.

## Test plan
- Single request: bank 5 requests with row 0x1ABCD, crow 3, dir 0; ready=1; ack in the first WAIT cycle. Required: xfer_bank=5, row=0x1ABCD, crow=3, dir=0; sync_done[5] 3 cycles after the request edge; stall low once req drops in IDLE.
- Simultaneous requests from banks 2, 9 and 15 out of reset. Required grant order: 2, 9, 15, each with its own payload, each followed by a single done pulse.
- All 16 banks re-request continuously. Required: grants cycle 0..15 with no bank granted twice before every other bank has been granted once.
- Backpressure: xfer_ready low for 7 cycles. Required: xfer_valid high and payload unchanged throughout; WAIT entered the cycle after ready rises.
- TIMEOUT=8 with no ack. Required: timeout_err set after 8 WAIT cycles and stays set; sync_done still pulsed; next request served normally.
- reset_n asserted mid-WAIT. Required: all outputs 0 immediately; IDLE after release; a late xfer_ack is ignored; a pending bank 0 request is granted first.

Source files
------------

// File: rtl/mem_sync_arbiter.sv
// mem_sync_arbiter: round-robin arbiter that shares one backing-store row
// transfer engine among all per-bank row-cache sync requesters. One bank is
// granted at a time; its command is latched, issued, waited on, and answered
// with a one-cycle done pulse to that bank.
module mem_sync_arbiter #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int CHWIDTH   = 5,
    parameter int TIMEOUT   = 1024,
    localparam int BW       = BGWIDTH + BAWIDTH,
    localparam int NBANKS   = 2 ** BW
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NBANKS-1:0]           sync_req,
    input  logic [NBANKS-1:0]           sync_dir,
    input  logic [NBANKS*ADDRWIDTH-1:0] req_row,
    input  logic [NBANKS*CHWIDTH-1:0]   req_crow,
    output logic [NBANKS-1:0]           sync_done,
    output logic                        xfer_valid,
    input  logic                        xfer_ready,
    output logic [BW-1:0]               xfer_bank,
    output logic [ADDRWIDTH-1:0]        xfer_row,
    output logic [CHWIDTH-1:0]          xfer_crow,
    output logic                        xfer_dir,
    input  logic                        xfer_ack,
    output logic                        stall,
    output logic                        timeout_err,
    output logic [1:0]                  dbg_state
);

    // Wait counter is wide enough to reach TIMEOUT-1; at least one bit.
    localparam int CW = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                 state_q;
    logic [BW-1:0]          rr_q;
    logic [CW-1:0]          cnt_q;
    logic [BW-1:0]          bank_q;
    logic [ADDRWIDTH-1:0]   row_q;
    logic [CHWIDTH-1:0]     crow_q;
    logic                   dir_q;
    logic                   valid_q;
    logic [NBANKS-1:0]      done_q;
    logic                   err_q;

    logic                   pick_vld;
    logic [BW-1:0]          pick_idx;
    logic [BW-1:0]          cand;
    logic                   wait_expired;

    // Round-robin pick: nearest requester after rr_q, wrapping modulo NBANKS.
    // Scanning from the farthest distance down lets the nearest one win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_q;
        cand     = '0;
        for (int i = NBANKS; i >= 1; i--) begin
            cand = rr_q + BW'(i);
            if (sync_req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign wait_expired = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Transfer handshake: the command is offered with xfer_valid and held
    // stable until the edge where xfer_valid & xfer_ready are both high;
    // completion is a single-cycle xfer_ack that only counts in WAIT.
    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rr_q    <= '1;
            cnt_q   <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            crow_q  <= '0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        bank_q  <= pick_idx;
                        row_q   <= req_row[int'(pick_idx)*ADDRWIDTH +: ADDRWIDTH];
                        crow_q  <= req_crow[int'(pick_idx)*CHWIDTH +: CHWIDTH];
                        dir_q   <= sync_dir[pick_idx];
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (xfer_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (xfer_ack) begin
                        done_q  <= {{(NBANKS-1){1'b0}}, 1'b1} << bank_q;
                        state_q <= S_DONE;
                    end else if (wait_expired) begin
                        err_q   <= 1'b1;
                        done_q  <= {{(NBANKS-1){1'b0}}, 1'b1} << bank_q;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    rr_q    <= bank_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall       = (|sync_req) | (state_q != S_IDLE);
    assign sync_done   = done_q;
    assign xfer_valid  = valid_q;
    assign xfer_bank   = bank_q;
    assign xfer_row    = row_q;
    assign xfer_crow   = crow_q;
    assign xfer_dir    = dir_q;
    assign timeout_err = err_q;
    assign dbg_state   = state_q;

endmodule
